// File: rtl/decseq_pkg.sv
// decseq_pkg: command encodings, FSM states and packed-words-per-polynomial table for decode_seq_ctrl
package decseq_pkg;
  localparam logic [2:0] LVL2 = 3'd2;
  localparam logic [2:0] LVL3 = 3'd3;
  localparam logic [2:0] LVL5 = 3'd5;
  localparam logic [2:0] MODE_T0 = 3'd0;
  localparam logic [2:0] MODE_T1 = 3'd1;
  localparam logic [2:0] MODE_S1 = 3'd2;
  localparam logic [2:0] MODE_S2 = 3'd3;
  localparam logic [2:0] MODE_W1 = 3'd4;
  localparam logic [2:0] MODE_Z  = 3'd5;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RUN, S_DRAIN, S_DONE} state_t;
  // 64-bit words per 256-coefficient polynomial; 0 marks an illegal {lvl,mode}
  function automatic logic [6:0] words_per_poly(input logic [2:0] lvl, input logic [2:0] mode);
    logic [6:0] w;
    w = mode == MODE_T0 ? 7'd52 :
        mode == MODE_T1 ? 7'd40 :
        (mode == MODE_S1 || mode == MODE_S2) ? (lvl == LVL3 ? 7'd16 : 7'd12) :
        mode == MODE_W1 ? (lvl == LVL2 ? 7'd24 : 7'd16) :
        mode == MODE_Z  ? (lvl == LVL2 ? 7'd72 : 7'd80) : 7'd0;
    return (lvl == LVL2 || lvl == LVL3 || lvl == LVL5) ? w : 7'd0;
  endfunction
endpackage

// File: rtl/decseq_word_fifo.sv
// decseq_word_fifo: 2-entry word FIFO between the source buffer and the decoder
module decseq_word_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic wp, rp, do_push, do_pop;
  assign do_pop = pop && count != 2'd0;
  assign do_push = push && (count != 2'd2 || do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= ~wp;
      end
      if (do_pop) rp <= ~rp;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
endmodule

// File: rtl/decode_seq_ctrl.sv
// decode_seq_ctrl: drives the coefficient decoder over whole polynomials, src buffer -> decoder -> dst RAM.
// Build option DECSEQ_CFG_CHECK_EN: illegal {sec_lvl,mode} commands are rejected with an err pulse.
module decode_seq_ctrl
  import decseq_pkg::*;
#(
  parameter int W        = 64,
  parameter int COEFF_W  = 23,
  parameter int OUTPUT_W = 4,
  parameter int SRC_AW   = 10,
  parameter int DST_AW   = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [2:0]                  cmd_sec_lvl,
  input  logic [2:0]                  cmd_mode,
  input  logic [3:0]                  cmd_npoly,
  input  logic [SRC_AW-1:0]           cmd_src_base,
  input  logic [DST_AW-1:0]           cmd_dst_base,
  output logic                        src_rd_en,
  output logic [SRC_AW-1:0]           src_rd_addr,
  input  logic [W-1:0]                src_rd_data,
  output logic [2:0]                  dec_sec_lvl,
  output logic [2:0]                  dec_mode,
  output logic                        dec_valid_i,
  input  logic                        dec_ready_i,
  output logic [W-1:0]                dec_di,
  input  logic [OUTPUT_W*COEFF_W-1:0] dec_samples,
  input  logic                        dec_valid_o,
  output logic                        dec_ready_o,
  output logic                        dst_we,
  output logic [DST_AW-1:0]           dst_addr,
  output logic [OUTPUT_W*COEFF_W-1:0] dst_wdata,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);
  state_t state, state_n;
  logic [6:0] wpp_in;
  logic accept, illegal, rd_pend, pop, cap;
  logic [1:0] fifo_cnt;
  logic [10:0] word_cnt, tot_words;
  logic [9:0] grp_cnt, tot_grps;
  logic [SRC_AW-1:0] src_base;
  logic [DST_AW-1:0] dst_base;
  assign wpp_in = words_per_poly(cmd_sec_lvl, cmd_mode);
  assign accept = cmd_valid && cmd_ready;
  assign pop = dec_valid_i && dec_ready_i;
  assign cap = dec_valid_o && dec_ready_o;
  assign dec_valid_i = fifo_cnt != 2'd0;
  assign src_rd_addr = src_base + SRC_AW'(word_cnt);
`ifdef DECSEQ_CFG_CHECK_EN
  assign illegal = wpp_in == 7'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst) err <= 1'b0;
    else err <= accept && illegal;
`else
  assign illegal = 1'b0;
  assign err = 1'b0;
`endif
  decseq_word_fifo #(.W(W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_pend),
    .din   (src_rd_data),
    .pop   (pop),
    .dout  (dec_di),
    .count (fifo_cnt)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (accept && !illegal) state_n = (cmd_npoly == 4'd0 || wpp_in == 7'd0) ? S_DONE : S_SETUP;
      S_SETUP: state_n = S_RUN;
      S_RUN:   if (word_cnt == tot_words && fifo_cnt == 2'd0 && !rd_pend) state_n = S_DRAIN;
      S_DRAIN: if (grp_cnt == tot_grps) state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end
  // read throttle counts words already buffered plus the one whose data is still in flight
  always_comb begin
    cmd_ready = state == S_IDLE;
    busy = state != S_IDLE;
    done = state == S_DONE;
    dec_ready_o = state == S_RUN || state == S_DRAIN;
    src_rd_en = state == S_RUN && word_cnt < tot_words && (3'(fifo_cnt) + 3'(rd_pend)) < 3'd2;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dec_sec_lvl <= 3'd0;
      dec_mode <= 3'd0;
      src_base <= '0;
      dst_base <= '0;
      tot_words <= 11'd0;
      tot_grps <= 10'd0;
      word_cnt <= 11'd0;
      grp_cnt <= 10'd0;
      rd_pend <= 1'b0;
      dst_we <= 1'b0;
      dst_addr <= '0;
      dst_wdata <= '0;
    end else begin
      rd_pend <= src_rd_en;
      dst_we <= cap;
      if (accept) begin
        dec_sec_lvl <= cmd_sec_lvl;
        dec_mode <= cmd_mode;
        src_base <= cmd_src_base;
        dst_base <= cmd_dst_base;
        tot_words <= 11'(cmd_npoly) * 11'(wpp_in);
        tot_grps <= 10'(cmd_npoly) * 10'(256 / OUTPUT_W);
        word_cnt <= 11'd0;
        grp_cnt <= 10'd0;
      end
      if (src_rd_en) word_cnt <= word_cnt + 11'd1;
      if (cap) begin
        grp_cnt <= grp_cnt + 10'd1;
        dst_addr <= dst_base + DST_AW'(grp_cnt);
        dst_wdata <= dec_samples;
      end
    end
endmodule

// File: tb/tb_decode_seq_ctrl.sv
// tb_decode_seq_ctrl: randomized scoreboard bench; models source memory and decoder, checks reads, words and writes
module tb_decode_seq_ctrl;
  localparam int SW = 4 * 23;
`ifdef DECSEQ_CFG_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [2:0] cmd_sec_lvl = '0, cmd_mode = '0;
  logic [3:0] cmd_npoly = '0;
  logic [9:0] cmd_src_base = '0, cmd_dst_base = '0;
  logic src_rd_en;
  logic [9:0] src_rd_addr;
  logic [63:0] src_rd_data = '0;
  logic [2:0] dec_sec_lvl, dec_mode;
  logic dec_valid_i, dec_ready_i = 1'b0;
  logic [63:0] dec_di;
  logic [SW-1:0] dec_samples = '0;
  logic dec_valid_o = 1'b0, dec_ready_o;
  logic dst_we;
  logic [9:0] dst_addr;
  logic [SW-1:0] dst_wdata;
  logic busy, done, err;

  int n_cmp = 0, n_bad = 0;
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, err_cnt = 0, occ = 0;
  int mc = 0, done_mc = 0, last_we_mc = 0, cyc = 0;
  int dm_wpp = 1, dm_in_poly = 0, dm_pend = 0, dm_gi = 0, ready_mode = 0;
  int d0, e0, r0, w0, m_issue, exp_rd, exp_wr;
  bit bad_cmd, lat_chk = 1'b0, mem_pend = 1'b0;
  logic [9:0] dm_dst_base = '0, mem_addr = '0;
  logic [2:0] exp_lvl = '0, exp_mode = '0;
  logic [9:0] rd_q[$];
  logic [63:0] wexp_q[$];
  logic [10+SW-1:0] wr_q[$];

  decode_seq_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sec_lvl(cmd_sec_lvl), .cmd_mode(cmd_mode), .cmd_npoly(cmd_npoly),
    .cmd_src_base(cmd_src_base), .cmd_dst_base(cmd_dst_base),
    .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
    .dec_sec_lvl(dec_sec_lvl), .dec_mode(dec_mode), .dec_valid_i(dec_valid_i),
    .dec_ready_i(dec_ready_i), .dec_di(dec_di), .dec_samples(dec_samples),
    .dec_valid_o(dec_valid_o), .dec_ready_o(dec_ready_o), .dst_we(dst_we),
    .dst_addr(dst_addr), .dst_wdata(dst_wdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [127:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0h where nothing was expected", name, act);
  endtask

  function automatic logic [63:0] memf(input logic [9:0] a);
    return {a, 22'(a * 22'd2654435), ~a, 22'h2A5A5A ^ 22'(a)};
  endfunction

  // bits per coefficient * 256 coefficients / 64-bit words
  function automatic int ref_wpp(input int lvl, input int mode);
    int bits;
    if (!(lvl inside {2, 3, 5}) || mode > 5) return 0;
    case (mode)
      0: bits = 13;
      1: bits = 10;
      2, 3: bits = lvl == 3 ? 4 : 3;
      4: bits = lvl == 2 ? 6 : 4;
      default: bits = lvl == 2 ? 18 : 20;
    endcase
    return bits * 256 / 64;
  endfunction

  // source buffer: data for the address read last cycle
  always @(negedge clk) begin
    src_rd_data = mem_pend ? memf(mem_addr) : {$urandom, $urandom};
    mem_pend = src_rd_en;
    mem_addr = src_rd_addr;
  end

  // decoder model: consumes words, emits 64 groups once a full polynomial has arrived
  always @(negedge clk) begin
    cyc++;
    dec_ready_i = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
    if (dec_valid_i && dec_ready_i) begin
      occ--;
      if (wexp_q.size() == 0) fail("word_extra", dec_di);
      else check("word", dec_di, wexp_q.pop_front());
      dm_in_poly++;
      if (dm_in_poly == dm_wpp) begin
        dm_in_poly = 0;
        dm_pend += 64;
      end
    end
    dec_valid_o = dm_pend > 0 && $urandom_range(0, 3) != 0;
    dec_samples = SW'({$urandom, $urandom, $urandom});
    if (dec_valid_o && dec_ready_o) begin
      wr_q.push_back({dm_dst_base + 10'(dm_gi), dec_samples});
      dm_gi++;
      dm_pend--;
    end
  end

  always @(negedge clk) begin
    #1;
    mc++;
    if (src_rd_en) begin
      rd_cnt++;
      occ++;
      if (rd_q.size() == 0) fail("rd_extra", src_rd_addr);
      else check("rd_addr", src_rd_addr, rd_q.pop_front());
      check("fifo_occ", occ >= 0 && occ <= 2, 1'b1);
      check("busy_cfg", {busy, cmd_ready, dec_sec_lvl, dec_mode}, {1'b1, 1'b0, exp_lvl, exp_mode});
    end
    if (dst_we) begin
      wr_cnt++;
      last_we_mc = mc;
      if (wr_q.size() == 0) fail("dst_extra", dst_addr);
      else check("dst", {dst_addr, dst_wdata}, wr_q.pop_front());
    end
    if (done) begin
      done_cnt++;
      done_mc = mc;
      if (lat_chk) check("done_lat", mc - last_we_mc, 1);
    end
    if (err) err_cnt++;
  end

  task automatic start_cmd(input int lvl, input int mode, input int np, input int sb, input int db, input int rm);
    int wpp;
    logic [9:0] a;
    wpp = ref_wpp(lvl, mode);
    ready_mode = rm;
    @(negedge clk);
    for (int t = 0; t < 200 && !cmd_ready; t++) @(negedge clk);
    check("cmd_ready_wait", cmd_ready, 1'b1);
    d0 = done_cnt; e0 = err_cnt; r0 = rd_cnt; w0 = wr_cnt; m_issue = mc;
    bad_cmd = wpp == 0;
    exp_rd = np * wpp;
    exp_wr = wpp > 0 ? np * 64 : 0;
    lat_chk = exp_wr > 0;
    dm_wpp = wpp > 0 ? wpp : 1; dm_in_poly = 0; dm_pend = 0; dm_gi = 0;
    dm_dst_base = 10'(db);
    exp_lvl = 3'(lvl); exp_mode = 3'(mode);
    for (int k = 0; k < exp_rd; k++) begin
      a = 10'(sb + k);
      rd_q.push_back(a);
      wexp_q.push_back(memf(a));
    end
    cmd_valid = 1'b1; cmd_sec_lvl = 3'(lvl); cmd_mode = 3'(mode); cmd_npoly = 4'(np);
    cmd_src_base = 10'(sb); cmd_dst_base = 10'(db);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_sec_lvl = 3'($urandom); cmd_mode = 3'($urandom); cmd_npoly = 4'($urandom);
    cmd_src_base = 10'($urandom); cmd_dst_base = 10'($urandom);
  endtask

  task automatic finish_cmd();
    int t;
    for (t = 0; t < 6000 && done_cnt == d0 && err_cnt == e0; t++) @(negedge clk);
    if (done_cnt == d0 && err_cnt == e0) fail("timeout", t);
    repeat (3) @(negedge clk);
    #2;
    check("err_pulses", err_cnt - e0, (CHK && bad_cmd) ? 1 : 0);
    check("done_pulses", done_cnt - d0, (CHK && bad_cmd) ? 0 : 1);
    check("rd_total", rd_cnt - r0, (CHK && bad_cmd) ? 0 : exp_rd);
    check("wr_total", wr_cnt - w0, exp_wr);
    check("queues_left", rd_q.size() + wexp_q.size() + wr_q.size(), 0);
    check("idle", {cmd_ready, busy, done}, 3'b100);
    if (exp_wr == 0 && !(CHK && bad_cmd)) check("noop_done_lat", done_mc - m_issue, 2);
    lat_chk = 1'b0;
  endtask

  task automatic run_cmd(input int lvl, input int mode, input int np, input int sb, input int db, input int rm);
    start_cmd(lvl, mode, np, sb, db, rm);
    finish_cmd();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("reset_ctrl", {src_rd_en, src_rd_addr, dec_sec_lvl, dec_mode, dec_valid_i, dec_ready_o,
                         dst_we, dst_addr, busy, done, err, cmd_ready}, 36'h1);
    @(negedge clk);
    rst = 1'b0;
    run_cmd(2, 2, 1, 'h10, 'h20, 0);
    run_cmd(3, 5, 4, $urandom_range(0, 1023), $urandom_range(0, 1023), 2);
    run_cmd(5, 0, 2, $urandom_range(0, 1023), $urandom_range(0, 1023), 1);
    run_cmd(2, 4, 0, 5, 6, 0);
    // abort a lvl2 T1 command after 30 reads
    start_cmd(2, 1, 1, $urandom_range(0, 1023), $urandom_range(0, 1023), 0);
    for (int t = 0; t < 500 && rd_cnt - r0 < 30; t++) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_ctrl", {src_rd_en, src_rd_addr, dec_sec_lvl, dec_mode, dec_valid_i, dec_ready_o,
                       dst_we, dst_addr, busy, done, err, cmd_ready}, 36'h1);
    check("rst_di", dec_di, 64'd0);
    check("rst_wdata", dst_wdata, '0);
    rd_q.delete(); wexp_q.delete(); wr_q.delete();
    dm_pend = 0; dm_in_poly = 0; occ = 0; lat_chk = 1'b0;
    r0 = rd_cnt; w0 = wr_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    check("rst_quiet", (rd_cnt - r0) + (wr_cnt - w0) + (done_cnt - d0), 0);
    run_cmd(2, 1, 1, $urandom_range(0, 1023), $urandom_range(0, 1023), 2);
    run_cmd(4, 2, 1, 7, 9, 0);
    run_cmd(3, 4, 1, 1020, 1000, 1);
    for (int i = 0; i < 8; i++) begin
      int lv;
      lv = $urandom_range(0, 2);
      run_cmd(lv == 0 ? 2 : lv == 1 ? 3 : 5, $urandom_range(0, 5), $urandom_range(1, 3),
              $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 2));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
